// File: rtl/cdc_fifo_write_arbiter_if.sv
// Write-side bundle between two valid/ready requesters, the arbiter and cdc_fifo.
// master = requesters plus FIFO environment, slave = the arbiter.
interface cdc_fifo_write_arbiter_if #(
   parameter int DATA_WIDTH = 4
);
   logic                  a_valid;
   logic [DATA_WIDTH-1:0] a_data;
   logic                  a_ready;
   logic                  b_valid;
   logic [DATA_WIDTH-1:0] b_data;
   logic                  b_ready;
   logic                  full;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  write_increment;
   logic                  owner;
   logic [7:0]            a_count;
   logic [7:0]            b_count;

   modport master (
      output a_valid, a_data, b_valid, b_data, full,
      input  a_ready, b_ready, write_data, write_increment, owner, a_count, b_count
   );

   modport slave (
      input  a_valid, a_data, b_valid, b_data, full,
      output a_ready, b_ready, write_data, write_increment, owner, a_count, b_count
   );
endinterface

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin arbiter sharing the cdc_fifo write port between requesters A and B,
// with a bounded burst per grant and a one-entry output register gated by full.
module cdc_fifo_write_arbiter #(
   parameter int DATA_WIDTH = 4,
   parameter int BURST_LEN  = 4
) (
   input logic                     write_clock,
   input logic                     write_reset,
   cdc_fifo_write_arbiter_if.slave bus
);
   // state | meaning
   // OWN_A | A holds the grant; burst_cnt counts its consecutive accepted words
   // OWN_B | B holds the grant; burst_cnt counts its consecutive accepted words
   typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

   localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);
   localparam logic [3:0] BURST_SAT = 4'd15;

   owner_t                state;
   owner_t                state_nxt;
   logic [3:0]            burst_cnt;
   logic [3:0]            burst_cnt_nxt;

   logic                  out_valid;
   logic                  out_src;
   logic [DATA_WIDTH-1:0] out_data;
   logic [7:0]            a_count;
   logic [7:0]            b_count;

   logic                  owner_valid;
   logic                  other_valid;
   logic                  keep;
   logic                  grant_valid;
   owner_t                grant_src;
   logic                  consume;
   logic                  slot_free;
   logic                  a_ready;
   logic                  b_ready;
   logic                  a_accept;
   logic                  b_accept;
   logic                  accept;

   always_ff @(posedge write_clock or posedge write_reset) begin
      if (write_reset) begin
         state     <= OWN_A;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end

   // Ownership only moves on an accepted word, so idle cycles keep the preference.
   always_comb begin
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
      if (accept) begin
         if (grant_src == state) begin
            if (burst_cnt != BURST_SAT) begin
               burst_cnt_nxt = burst_cnt + 4'd1;
            end
         end else begin
            state_nxt     = grant_src;
            burst_cnt_nxt = 4'd1;
         end
      end
   end

   always_comb begin
      consume     = out_valid & ~bus.full;
      slot_free   = ~out_valid | consume;
      owner_valid = (state == OWN_A) ? bus.a_valid : bus.b_valid;
      other_valid = (state == OWN_A) ? bus.b_valid : bus.a_valid;
      keep        = owner_valid & ((burst_cnt < BURST_MAX) | ~other_valid);
      grant_valid = 1'b0;
      grant_src   = state;
      if (keep) begin
         grant_valid = 1'b1;
         grant_src   = state;
      end else if (other_valid) begin
         grant_valid = 1'b1;
         grant_src   = (state == OWN_A) ? OWN_B : OWN_A;
      end
      // Readies are forced low during reset even though the slot looks free.
      a_ready  = ~write_reset & slot_free & grant_valid & (grant_src == OWN_A);
      b_ready  = ~write_reset & slot_free & grant_valid & (grant_src == OWN_B);
      a_accept = bus.a_valid & a_ready;
      b_accept = bus.b_valid & b_ready;
      accept   = a_accept | b_accept;
   end

   always_ff @(posedge write_clock or posedge write_reset) begin
      if (write_reset) begin
         out_valid <= 1'b0;
         out_src   <= 1'b0;
         out_data  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_src   <= b_accept;
         out_data  <= b_accept ? bus.b_data : bus.a_data;
      end else if (consume) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge write_clock or posedge write_reset) begin
      if (write_reset) begin
         a_count <= '0;
         b_count <= '0;
      end else if (consume) begin
         if (out_src) begin
            b_count <= b_count + 8'd1;
         end else begin
            a_count <= a_count + 8'd1;
         end
      end
   end

   assign bus.a_ready         = a_ready;
   assign bus.b_ready         = b_ready;
   assign bus.write_increment = consume;
   assign bus.write_data      = out_data;
   assign bus.owner           = (state == OWN_B);
   assign bus.a_count         = a_count;
   assign bus.b_count         = b_count;
endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Bench for cdc_fifo_write_arbiter: reset/vector table, directed corner sequences and
// random traffic against a queue-based reference of the arbitration rules.
`timescale 1ns/1ps
module tb_cdc_fifo_write_arbiter;
   localparam int DATA_WIDTH = 4;
   localparam int BURST_LEN  = 4;

   logic write_clock = 1'b0;
   logic write_reset;

   always #5 write_clock = ~write_clock;

   cdc_fifo_write_arbiter_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

   cdc_fifo_write_arbiter #(.DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN)) dut (
      .write_clock(write_clock),
      .write_reset(write_reset),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int src;
      int data;
   } word_t;

   typedef struct {
      int av; int ad; int bv; int bd; int full;
      int ea; int eb; int ewi; int ewd; int eown;
   } vec_t;

   word_t pend[$];
   int    acc_log[$];
   int    m_owner, m_run, m_a_cnt, m_b_cnt, m_last_data;
   vec_t  vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int av, input int ad, input int bv, input int bd, input int f);
      bus.a_valid = av[0];
      bus.a_data  = DATA_WIDTH'(ad);
      bus.b_valid = bv[0];
      bus.b_data  = DATA_WIDTH'(bd);
      bus.full    = f[0];
   endtask

   task automatic m_reset();
      pend.delete();
      acc_log.delete();
      m_owner = 0; m_run = 0; m_a_cnt = 0; m_b_cnt = 0; m_last_data = 0;
   endtask

   task automatic accept_word(input int src, input int data);
      pend.push_back('{src: src, data: data});
      acc_log.push_back(src);
      m_last_data = data;
      if (src == m_owner) begin
         m_run = (m_run < 15) ? m_run + 1 : 15;
      end else begin
         m_owner = src;
         m_run   = 1;
      end
   endtask

   // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
   task automatic step();
      int    av, bv, ov, tv, gv, gs, wi, fr, ar, br;
      word_t w;
      av = int'(bus.a_valid);
      bv = int'(bus.b_valid);
      wi = (pend.size() != 0 && !bus.full) ? 1 : 0;
      fr = (pend.size() == 0 || wi != 0) ? 1 : 0;
      ov = (m_owner == 0) ? av : bv;
      tv = (m_owner == 0) ? bv : av;
      gv = 0; gs = 0;
      if (ov != 0 && (m_run < BURST_LEN || tv == 0)) begin
         gv = 1; gs = m_owner;
      end else if (tv != 0) begin
         gv = 1; gs = 1 - m_owner;
      end
      ar = (fr != 0 && gv != 0 && gs == 0) ? 1 : 0;
      br = (fr != 0 && gv != 0 && gs == 1) ? 1 : 0;
      @(negedge write_clock);
      check("a_ready", bus.a_ready, ar);
      check("b_ready", bus.b_ready, br);
      check("write_increment", bus.write_increment, wi);
      check("write_data", bus.write_data, m_last_data);
      check("owner", bus.owner, m_owner);
      check("a_count", bus.a_count, m_a_cnt);
      check("b_count", bus.b_count, m_b_cnt);
      @(posedge write_clock);
      if (wi != 0) begin
         w = pend.pop_front();
         if (w.src == 0) m_a_cnt = (m_a_cnt + 1) % 256;
         else            m_b_cnt = (m_b_cnt + 1) % 256;
      end
      if (ar != 0 && av != 0)      accept_word(0, int'(bus.a_data));
      else if (br != 0 && bv != 0) accept_word(1, int'(bus.b_data));
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      @(negedge write_clock);
      write_reset = 1'b1;
      #2;
      write_reset = 1'b0;
      m_reset();
      @(posedge write_clock);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1, 5, 0, 0, 0,   1, 0, 0, 0, 0};
      vecs[1] = '{1, 6, 1, 9, 0,   1, 0, 1, 5, 0};
      vecs[2] = '{1, 7, 1, 9, 1,   0, 0, 0, 6, 0};
      vecs[3] = '{1, 7, 1, 9, 0,   1, 0, 1, 6, 0};
      vecs[4] = '{1, 8, 1, 9, 0,   1, 0, 1, 7, 0};
      vecs[5] = '{1, 1, 1, 9, 0,   0, 1, 1, 8, 0};
      vecs[6] = '{0, 0, 0, 0, 0,   0, 0, 1, 9, 1};
      vecs[7] = '{0, 0, 0, 0, 0,   0, 0, 0, 9, 1};
      vecs[8] = '{1, 3, 0, 0, 0,   1, 0, 0, 9, 1};
      vecs[9] = '{0, 0, 0, 0, 0,   0, 0, 1, 3, 0};
      m_reset();

      // Reset held across clock edges with A requesting.
      write_reset = 1'b1;
      drive(1, 5, 0, 0, 0);
      #12;
      check("rst_a_ready", bus.a_ready, 0);
      check("rst_write_increment", bus.write_increment, 0);
      check("rst_write_data", bus.write_data, 0);
      @(negedge write_clock);
      write_reset = 1'b0;
      #1;
      check("rel_a_count", bus.a_count, 0);
      check("rel_owner", bus.owner, 0);

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].full);
         #1;
         check($sformatf("vec%0d_a_ready", i), bus.a_ready, vecs[i].ea);
         check($sformatf("vec%0d_b_ready", i), bus.b_ready, vecs[i].eb);
         check($sformatf("vec%0d_write_increment", i), bus.write_increment, vecs[i].ewi);
         check($sformatf("vec%0d_write_data", i), bus.write_data, vecs[i].ewd);
         check($sformatf("vec%0d_owner", i), bus.owner, vecs[i].eown);
         @(negedge write_clock);
      end

      // A alone streams 1..6.
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         drive(1, i, 0, 0, 0);
         step();
      end
      drive(0, 0, 0, 0, 0);
      step();
      check("stream_a_count", bus.a_count, 6);
      check("stream_b_count", bus.b_count, 0);

      // Both continuously valid: bursts of BURST_LEN alternate.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(1, int'($urandom_range(0, 15)), 1, int'($urandom_range(0, 15)), 0);
         step();
      end
      for (int i = 0; i < 16; i++) begin
         check($sformatf("burst_src%0d", i), acc_log[i], (i / BURST_LEN) % 2);
      end
      check("burst_a_count", bus.a_count, 8);
      check("burst_b_count", bus.b_count, 8);

      // Simultaneous first request after reset, then B once A drops.
      do_reset();
      drive(1, 3, 1, 4, 0);
      step();
      drive(0, 0, 1, 4, 0);
      step();
      check("simul_first", acc_log[0], 0);
      check("simul_second", acc_log[1], 1);

      // Word 0x9 held while full for 5 cycles.
      drive(1, 9, 0, 0, 0);
      step();
      for (int i = 0; i < 5; i++) begin
         drive(1, 2, 1, 7, 1);
         step();
         check($sformatf("full_hold%0d", i), bus.write_data, 9);
      end
      drive(1, 2, 1, 7, 0);
      step();
      check("full_release_data", bus.write_data, 2);
      drive(0, 0, 0, 0, 0);
      step();
      step();

      // 256 A writes wrap a_count, then reset with a word held.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         drive(1, i % 16, 0, 0, 0);
         step();
      end
      drive(0, 0, 0, 0, 0);
      step();
      check("wrap_a_count", bus.a_count, 0);
      drive(1, 6, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0);
      check("pre_reset_write_increment", bus.write_increment, 1);
      write_reset = 1'b1;
      #1;
      check("mid_reset_write_increment", bus.write_increment, 0);
      check("mid_reset_write_data", bus.write_data, 0);
      check("mid_reset_a_ready", bus.a_ready, 0);
      check("mid_reset_owner", bus.owner, 0);
      @(negedge write_clock);
      write_reset = 1'b0;
      m_reset();
      @(posedge write_clock);
      #1;

      // Random traffic against the reference.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 15)),
               ($urandom_range(0, 4) == 0) ? 1 : 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cdc_fifo_write_arbiter.md
Name: cdc_fifo_write_arbiter

Overview:
- Shares the single write port of cdc_fifo (write-clock domain) between two requesters, A and B.
- Each requester uses a valid/ready handshake.
- Round-robin arbitration with a bounded burst per grant.
- A one-entry output register drives write_data. write_increment is qualified by the FIFO full flag, so no word is ever lost or duplicated.

Parameters:
- DATA_WIDTH, 4, width of each data word (matches cdc_fifo DATA_WIDTH).
- BURST_LEN, 4, maximum consecutive words granted to one requester while the other is waiting; legal range 1..15.

Ports:
- write_clock  input  1  write-domain clock; all state updates on rising edge
- write_reset  input  1  asynchronous, active-high reset
- a_valid  input  1  requester A has a word
- a_data  input  DATA_WIDTH  requester A word
- a_ready  output  1  A word accepted this cycle when a_valid & a_ready
- b_valid  input  1  requester B has a word
- b_data  input  DATA_WIDTH  requester B word
- b_ready  output  1  B word accepted this cycle when b_valid & b_ready
- full  input  1  cdc_fifo full flag
- write_data  output  DATA_WIDTH  to cdc_fifo write_data
- write_increment  output  1  to cdc_fifo write_increment
- owner  output  1  current grant owner (0=A, 1=B)
- a_count  output  8  words from A written into FIFO, wraps 255->0
- b_count  output  8  words from B written into FIFO, wraps 255->0

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_valid=0, write_data=0, owner=0, burst_cnt=0, a_count=0, b_count=0.
  - write_increment, a_ready and b_ready are 0 while write_reset=1.
- Output stage:
  - out_valid, out_src and write_data are registers.
  - write_increment = out_valid & ~full (combinational).
  - consume = write_increment.
  - slot_free = ~out_valid | consume.
- Grant (combinational, from registered owner and burst_cnt):
  - keep = owner's valid & (burst_cnt < BURST_LEN | other's valid = 0).
  - If keep, grant owner; else if the other requester is valid, grant the other; else no grant.
  - a_ready = slot_free & grant==A; b_ready = slot_free & grant==B.
  - At most one ready is high per cycle.
- On an accepted word (x_valid & x_ready):
  - write_data <= x_data, out_src <= x, out_valid <= 1.
  - If x==owner, burst_cnt <= burst_cnt+1, saturating at 15.
  - If x!=owner, owner <= x and burst_cnt <= 1.
- On consume without accept: out_valid <= 0.
- On consume and accept in the same cycle: the register is reloaded. Throughput is 1 word/cycle while not full.
- Counters: a_count increments on consume with out_src=A; b_count increments on consume with out_src=B. Both are 8-bit and wrap.
- Latency: a word accepted at edge N is presented on write_data after N. It is written at edge N+1 if full=0 in that cycle.
- Full:
  - While full=1, write_increment=0 and the held word stays stable.
  - No new word is accepted while out_valid=1 and full=1.
  - Words are never dropped.
- Idle: with neither requester valid, owner and burst_cnt hold. A new request from either requester is granted the next cycle without preference reset.
- Simultaneous first request after reset: A wins (owner=0).
- Burst limit:
  - After BURST_LEN consecutive accepts from the owner while the other is valid, the next grant goes to the other.
  - If the other is not valid, the owner continues without limit; burst_cnt saturates.
- Reset mid-operation: the held word is discarded and counts clear. The FIFO itself is reset separately by the same write_reset.

Test Plan:
- Reset with a_valid=1 during reset -> a_ready=0, write_increment=0; after release a_count=0, owner=0; first A word 0x5 appears on write_data one cycle after accept.
- A alone streams 6 words 1..6, full=0 -> 6 consecutive write_increment pulses, data 1..6 in order, a_count=6, b_count=0.
- A and B both continuously valid, BURST_LEN=4 -> accepted sources AAAABBBBAAAA..., write_increment high every cycle, a_count=b_count after 8k writes.
- Word 0x9 held; full=1 for 5 cycles -> write_increment=0, write_data=0x9 stable, a_ready=b_ready=0; full drops -> single write of 0x9, then accepts resume.
- Both requesters raise valid in the same cycle from idle after reset -> A granted first; B granted immediately once A deasserts valid.
- 256 A writes -> a_count wraps to 0. Then assert write_reset mid-transfer with out_valid=1 -> out_valid=0 and write_increment=0 immediately.
